ddr_rd_arbiter: RTL and testbench

Round-robin arbiter that shares the single DDR burst-read channel among `NUM_REQ` weight-fetch clients, for example the Q/K/V/MLP weight FIFOs. Each client uses the same burst protocol it would use on a dedicated DDR port. The arbiter grants one client at a time and forwards that client's address and length to DDR. It steers `rd_burst_valid`/`rd_burst_finish` back to the granted client only, and broadcasts `rd_burst_data`. It sits between the weight FIFOs and the DDR read master.

---
 rtl/ddr_rd_arbiter_pkg.sv | 26 ++
 rtl/ddr_rd_arbiter_rr_pick.sv | 39 +++
 rtl/ddr_rd_arbiter.sv | 153 +++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rd_arbiter_pkg.sv
// ddr_rd_arbiter_pkg
//   Shared constants and types for the DDR burst-read arbiter.
//   The HP_* widths mirror the project-wide hyper parameters
//   (DATA_WIDTH / ADDR_SIZE / LEN_WIDTH). This package also carries
//   the arbiter client count and the fixed client slot assignment.
//   Optional feature macro used by the arbiter: DDR_ARB_BEAT_CHECK_EN.
package ddr_rd_arbiter_pkg;

  localparam int HP_DATA_WIDTH   = 64;  // DDR beat width
  localparam int HP_ADDR_SIZE    = 32;  // byte address width
  localparam int HP_LEN_WIDTH    = 10;  // burst length width, in beats

  localparam int DDR_ARB_NUM_REQ = 4;

  // Client slots on the shared read channel
  localparam int DDR_ARB_CLIENT_Q   = 0;
  localparam int DDR_ARB_CLIENT_K   = 1;
  localparam int DDR_ARB_CLIENT_V   = 2;
  localparam int DDR_ARB_CLIENT_MLP = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ddr_rd_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector: returns the first set request bit
//   at or after i_ptr, wrapping modulo N.
//   Ports:
//     i_req    [N-1:0]  request vector
//     i_ptr    [IW-1:0] search start index (must be < N)
//     o_found           any request set
//     o_onehot [N-1:0]  one-hot of the selected client, 0 if none
//     o_idx    [IW-1:0] index of the selected client, 0 if none
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_j;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    o_found  = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    w_j      = '0;
    for (int off = N - 1; off >= 0; off--) begin
      w_j = IW'((int'(i_ptr) + off) % N);
      if (i_req[w_j]) begin
        o_found  = 1'b1;
        o_idx    = w_j;
        o_onehot = N'(1) << w_j;
      end
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter
//   Round-robin sharing of one DDR burst-read channel among NUM_REQ clients.
//   One client is granted at a time; its address/length are latched onto the
//   DDR request, valid/finish are steered to it only, data is broadcast.
//   A grant always runs until rd_burst_finish and is followed by one IDLE cycle.
//   Handshake: rd_burst_req rises one cycle after a request is seen in IDLE
//   and stays high (address/length stable) until the cycle after
//   rd_burst_finish; i_req[k] is held by the client until its own finish.
//   Optional: define DDR_ARB_BEAT_CHECK_EN to add a beat counter and the
//   sticky o_len_err flag.
//   Ports:
//     s_clk, s_rst           clock, async active-high reset
//     i_req/i_addr/i_len     packed per-client requests (slice k = client k)
//     o_data/o_valid/o_finish  data broadcast, gated valid/finish per client
//     o_grant                one-hot current grant, 0 when idle
//     rd_burst_*             DDR read master interface
//     o_len_err              sticky length error (DDR_ARB_BEAT_CHECK_EN only)
//     o_dbg_state            FSM state, for observation
module ddr_rd_arbiter
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DDR_ARB_NUM_REQ,
  parameter int DATA_WIDTH = HP_DATA_WIDTH,
  parameter int ADDR_SIZE  = HP_ADDR_SIZE,
  parameter int LEN_WIDTH  = HP_LEN_WIDTH
) (
  input  logic                           s_clk,
  input  logic                           s_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   i_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   i_len,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [NUM_REQ-1:0]             o_valid,
  output logic [NUM_REQ-1:0]             o_finish,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           rd_burst_req,
  output logic [ADDR_SIZE-1:0]           rd_burst_addr,
  output logic [LEN_WIDTH-1:0]           rd_burst_len,
  input  logic [DATA_WIDTH-1:0]          rd_burst_data,
  input  logic                           rd_burst_valid,
  input  logic                           rd_burst_finish,
`ifdef DDR_ARB_BEAT_CHECK_EN
  output logic                           o_len_err,
`endif
  output arb_state_e                     o_dbg_state
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e          r_state;
  arb_state_e          w_next;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_idx;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_req;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [LEN_WIDTH-1:0] r_len;

  logic                w_found;
  logic [NUM_REQ-1:0]  w_onehot;
  logic [IW-1:0]       w_idx;
  logic                w_load;
  logic                w_done;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  // State register
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_found)         w_next = ST_BURST;
      ST_BURST: if (rd_burst_finish) w_next = ST_IDLE;
      default:                       w_next = ST_IDLE;
    endcase
  end

  // Outputs; r_grant is 0 in IDLE, so stray DDR strobes reach no client.
  always_comb begin
    w_load   = (r_state == ST_IDLE) && w_found;
    w_done   = (r_state == ST_BURST) && rd_burst_finish;
    o_valid  = r_grant & {NUM_REQ{rd_burst_valid}};
    o_finish = r_grant & {NUM_REQ{rd_burst_finish}};
  end

  // Grant datapath; address/length are left as-is after finish.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_grant <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_grant <= w_onehot;
      r_req   <= 1'b1;
      r_addr  <= i_addr[w_idx*ADDR_SIZE +: ADDR_SIZE];
      r_len   <= i_len[w_idx*LEN_WIDTH +: LEN_WIDTH];
      r_idx   <= w_idx;
    end else if (w_done) begin
      r_grant <= '0;
      r_req   <= 1'b0;
      r_ptr   <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    end
  end

`ifdef DDR_ARB_BEAT_CHECK_EN
  logic [LEN_WIDTH:0] r_beat_cnt;
  logic [LEN_WIDTH:0] w_cnt_final;
  logic               r_len_err;

  // Count as seen at finish, including a beat that arrives with finish.
  assign w_cnt_final = r_beat_cnt + (LEN_WIDTH + 1)'(rd_burst_valid);

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_load)
        r_beat_cnt <= '0;
      else if ((r_state == ST_BURST) && rd_burst_valid)
        r_beat_cnt <= r_beat_cnt + 1'b1;
      if (w_done && (w_cnt_final != {1'b0, r_len}))
        r_len_err <= 1'b1;
      if ((r_state == ST_IDLE) && (rd_burst_valid || rd_burst_finish))
        r_len_err <= 1'b1;
    end
  end

  assign o_len_err = r_len_err;
`endif

  assign o_data        = rd_burst_data;
  assign o_grant       = r_grant;
  assign rd_burst_req  = r_req;
  assign rd_burst_addr = r_addr;
  assign rd_burst_len  = r_len;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter
//   Directed bench for ddr_rd_arbiter (NUM_REQ=4). A round-robin reference
//   model predicts each grant ({grant, addr, len}) into exp_q when requests
//   are driven; DDR beats are queued in data_q as they are driven.
//   Honors DDR_ARB_BEAT_CHECK_EN when defined.
module tb_ddr_rd_arbiter;
  import ddr_rd_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 10;
  localparam int W  = NR + AW + LW;

  logic               s_clk;
  logic               s_rst;
  logic [NR-1:0]      i_req;
  logic [NR*AW-1:0]   i_addr;
  logic [NR*LW-1:0]   i_len;
  logic [DW-1:0]      o_data;
  logic [NR-1:0]      o_valid;
  logic [NR-1:0]      o_finish;
  logic [NR-1:0]      o_grant;
  logic               rd_burst_req;
  logic [AW-1:0]      rd_burst_addr;
  logic [LW-1:0]      rd_burst_len;
  logic [DW-1:0]      rd_burst_data;
  logic               rd_burst_valid;
  logic               rd_burst_finish;
`ifdef DDR_ARB_BEAT_CHECK_EN
  logic               o_len_err;
`endif
  arb_state_e         o_dbg_state;

  ddr_rd_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_SIZE(AW), .LEN_WIDTH(LW)) dut (
    .s_clk           (s_clk),
    .s_rst           (s_rst),
    .i_req           (i_req),
    .i_addr          (i_addr),
    .i_len           (i_len),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .o_finish        (o_finish),
    .o_grant         (o_grant),
    .rd_burst_req    (rd_burst_req),
    .rd_burst_addr   (rd_burst_addr),
    .rd_burst_len    (rd_burst_len),
    .rd_burst_data   (rd_burst_data),
    .rd_burst_valid  (rd_burst_valid),
    .rd_burst_finish (rd_burst_finish),
`ifdef DDR_ARB_BEAT_CHECK_EN
    .o_len_err       (o_len_err),
`endif
    .o_dbg_state     (o_dbg_state)
  );

  // Clock / reset
  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  // Scoreboard
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] data_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            m_ptr    = 0;

  logic [AW-1:0] addr_tb [NR];
  logic [LW-1:0] len_tb  [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  // Reference round-robin: first set bit at or after m_ptr.
  function automatic int model_pick(input logic [NR-1:0] req);
    int j;
    for (int off = 0; off < NR; off++) begin
      j = (m_ptr + off) % NR;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic push_expect(input logic [NR-1:0] req);
    int k;
    logic [NR-1:0] g;
    k = model_pick(req);
    g = NR'(1) << k;
    exp_q.push_back({g, addr_tb[k], len_tb[k]});
  endtask

  // Driver: wait for the next DDR request, check it, then return nbeats beats
  // with finish on the last (nbeats<0: use the granted length; 0: bare finish).
  task automatic serve(input int nbeats_in, input logic [NR-1:0] drop_mask, output int waits);
    logic [W-1:0]  e;
    logic [NR-1:0] g;
    logic [DW-1:0] d;
    int idx, nb, fin_cnt;
    waits = 0;
    do begin
      tick();
      waits++;
    end while (!rd_burst_req && waits < 20);
    chk("req_rise", rd_burst_req, 1);
    e = exp_q.pop_front();
    if (!rd_burst_req) return;
    g = e[W-1 -: NR];
    idx = 0;
    for (int k = 0; k < NR; k++) if (g[k]) idx = k;
    chk("grant", o_grant, g);
    chk("addr", rd_burst_addr, e[LW +: AW]);
    chk("len", rd_burst_len, e[LW-1:0]);
    chk("state_burst", o_dbg_state, ST_BURST);
    nb = (nbeats_in < 0) ? int'(e[LW-1:0]) : nbeats_in;
    fin_cnt = 0;
    if (nb == 0) begin
      rd_burst_valid = 1'b0;
      rd_burst_finish = 1'b1;
      #1;
      chk("fin_only_valid", o_valid, 0);
      chk("fin_only_finish", o_finish, g);
      if (o_finish != 0) fin_cnt++;
      tick();
    end else begin
      for (int b = 0; b < nb; b++) begin
        d = {$urandom, $urandom};
        data_q.push_back(d);
        rd_burst_data = d;
        rd_burst_valid = 1'b1;
        rd_burst_finish = (b == nb - 1);
        if (b == 2) i_req = i_req & ~drop_mask;
        #1;
        chk("beat_valid", o_valid, g);
        chk("beat_data", o_data, data_q.pop_front());
        chk("beat_finish", o_finish, (b == nb - 1) ? g : '0);
        if (o_finish != 0) fin_cnt++;
        tick();
      end
    end
    rd_burst_valid = 1'b0;
    rd_burst_finish = 1'b0;
    #1;
    chk("req_fall", rd_burst_req, 0);
    chk("grant_clear", o_grant, 0);
    chk("finish_once", fin_cnt, 1);
    chk("state_idle", o_dbg_state, ST_IDLE);
    m_ptr = (idx + 1) % NR;
  endtask

  initial begin : main
    int w;
    logic [W-1:0] e;
    addr_tb[0] = 32'h0000_1000; len_tb[0] = 10'd32;
    addr_tb[1] = 32'h2000_0040; len_tb[1] = 10'd5;
    addr_tb[2] = 32'h0000_3000; len_tb[2] = 10'd0;
    addr_tb[3] = 32'hFFFF_FFC0; len_tb[3] = 10'd3;
    for (int k = 0; k < NR; k++) begin
      i_addr[k*AW +: AW] = addr_tb[k];
      i_len[k*LW +: LW]  = len_tb[k];
    end
    s_rst = 1'b1;
    i_req = '0;
    rd_burst_data = '0;
    rd_burst_valid = 1'b0;
    rd_burst_finish = 1'b0;

    // Reset state
    #12;
    chk("rst_req", rd_burst_req, 0);
    chk("rst_addr", rd_burst_addr, 0);
    chk("rst_len", rd_burst_len, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_state", o_dbg_state, ST_IDLE);
`ifdef DDR_ARB_BEAT_CHECK_EN
    chk("rst_len_err", o_len_err, 0);
`endif
    tick();
    s_rst = 1'b0;
    tick();

    // Stray DDR strobes while idle reach no client
    rd_burst_valid = 1'b1;
    rd_burst_finish = 1'b1;
    #1;
    chk("idle_valid", o_valid, 0);
    chk("idle_finish", o_finish, 0);
    tick();
    rd_burst_valid = 1'b0;
    rd_burst_finish = 1'b0;
    chk("idle_req", rd_burst_req, 0);
    chk("idle_grant", o_grant, 0);
`ifdef DDR_ARB_BEAT_CHECK_EN
    chk("idle_len_err", o_len_err, 1);
    s_rst = 1'b1;
    #1;
    chk("len_err_rst", o_len_err, 0);
    tick();
    s_rst = 1'b0;
`endif

    // Single client, 32 beats
    i_req = 4'b0001;
    push_expect(i_req);
    chk("t1_req_cycle0", rd_burst_req, 0);
    serve(-1, '0, w);
    chk("t1_latency", w, 1);
    i_req = '0;
    tick();
    tick();

    // All four requesting continuously: one idle cycle between bursts
    i_req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      push_expect(i_req);
      serve(-1, '0, w);
      chk("rr_gap", w, 1);
    end
    i_req = '0;
    tick();

    // Pointer wrap: serve 3, then 0 and 3 requesting
    i_req = 4'b1000;
    push_expect(i_req);
    serve(-1, '0, w);
    i_req = 4'b1001;
    push_expect(i_req);
    serve(-1, '0, w);
    push_expect(i_req);
    serve(-1, '0, w);
    i_req = '0;
    tick();

    // Client 1 drops its request mid-burst
    i_req = 4'b0010;
    push_expect(i_req);
    serve(-1, 4'b0010, w);
    tick();
    tick();
    chk("drop_no_regrant", rd_burst_req, 0);

    // Reset pulsed mid-burst
    i_req = 4'b0001;
    push_expect(i_req);
    tick();
    e = exp_q.pop_front();
    chk("rst_mid_req", rd_burst_req, 1);
    chk("rst_mid_grant", o_grant, e[W-1 -: NR]);
    rd_burst_valid = 1'b1;
    rd_burst_data = {$urandom, $urandom};
    tick();
    #2;
    s_rst = 1'b1;
    #1;
    chk("async_rst_req", rd_burst_req, 0);
    chk("async_rst_grant", o_grant, 0);
    chk("async_rst_addr", rd_burst_addr, 0);
    chk("async_rst_len", rd_burst_len, 0);
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_state", o_dbg_state, ST_IDLE);
    rd_burst_valid = 1'b0;
    i_req = '0;
    m_ptr = 0;
    tick();
    s_rst = 1'b0;
    tick();

    // Client 2 after reset, length 0 forwarded, bare finish
    i_req = 4'b0100;
    push_expect(i_req);
    serve(-1, '0, w);
    chk("post_rst_latency", w, 1);
    i_req = '0;
    tick();

`ifdef DDR_ARB_BEAT_CHECK_EN
    chk("len0_no_err", o_len_err, 0);
    // Short burst: 31 beats against length 32
    i_req = 4'b0001;
    push_expect(i_req);
    serve(31, '0, w);
    chk("short_len_err", o_len_err, 1);
    i_req = 4'b0010;
    push_expect(i_req);
    serve(-1, '0, w);
    i_req = '0;
    tick();
    chk("len_err_sticky", o_len_err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
